usb_ep_in_fifo: RTL and testbench
=================================

USB_EP_IN_FIFO -- requirements
Module: usb_ep_in_fifo

Interface
REQ-001 SHALL have parameter EP_DATA_WID, default 8: byte-lane width of endpoint data.
REQ-002 SHALL have parameter DEPTH, default 64: entry count; a power of two, at least 2.
REQ-003 SHALL have port clk48_i, input, 1 bit: the only clock; all logic is synced to it.
REQ-004 SHALL have port rst_n_i, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port wrData_i, input, EP_DATA_WID bits: user byte to enqueue.
REQ-006 SHALL have port wrValid_i, input, 1 bit: push request for wrData_i.
REQ-007 SHALL have port full_o, output, 1 bit: no committed space left; a push is ignored.
REQ-008 SHALL have port fillLevel_o, output, $clog2(DEPTH)+1 bits: entries not yet committed.
REQ-009 SHALL have port EP_IN_popData_i, input, 1 bit: protocol engine consumes the byte on EP_IN_data_o.
REQ-010 SHALL have port EP_IN_popTransDone_i, input, 1 bit: the current IN transaction ended.
REQ-011 SHALL have port EP_IN_popTransSuccess_i, input, 1 bit: host ACKed; sampled only when TransDone=1.
REQ-012 SHALL have port EP_IN_dataAvailable_o, output, 1 bit: at least one unread byte exists.
REQ-013 SHALL have port EP_IN_data_o, output, EP_DATA_WID bits: byte at the read pointer, first-word-fall-through.

Function
REQ-014 SHALL keep three pointers of width $clog2(DEPTH)+1: wrPtr, rdPtr (speculative) and cmtPtr (committed).
REQ-015 SHALL wrap all pointer arithmetic modulo 2*DEPTH, with the MSB distinguishing full from empty.
REQ-016 SHALL drive full_o = (wrPtr - cmtPtr == DEPTH) and fillLevel_o = wrPtr - cmtPtr.
REQ-017 SHALL drive EP_IN_dataAvailable_o = (rdPtr != wrPtr) combinationally.
REQ-018 SHALL drive EP_IN_data_o = mem[rdPtr] as a combinational read, with no added latency.
REQ-019 SHALL, on wrValid_i && !full_o, write mem[wrPtr] and increment wrPtr at the clock edge; a push while full is dropped with no state change.
REQ-020 SHALL, on EP_IN_popData_i && EP_IN_dataAvailable_o, increment rdPtr; a pop while empty is ignored.
REQ-021 SHALL implement an FSM with states IDLE and ACTIVE; a valid pop in IDLE moves it to ACTIVE.
REQ-022 SHALL, on TransDone && Success, set cmtPtr to rdPtr plus any same-cycle valid pop, then go to IDLE.
REQ-023 SHALL, on TransDone && !Success, restore rdPtr to cmtPtr, discard any same-cycle pop and go to IDLE, so the retry resends identical bytes.
REQ-024 SHALL treat TransDone in IDLE with no pop as a no-op, whether Success is 1 or 0.
REQ-025 SHALL accept a push in the same cycle as a pop, commit or rollback; the pointers update independently.
REQ-026 SHALL keep full_o asserted while popped-but-uncommitted bytes are pending, since space frees only on commit.

Reset
REQ-027 SHALL, when rst_n_i=0 at a clock edge, zero wrPtr, rdPtr and cmtPtr and set the FSM to IDLE.
REQ-028 SHALL give outputs after reset: full_o=0, fillLevel_o=0, EP_IN_dataAvailable_o=0.
REQ-029 SHALL leave memory contents unreset; EP_IN_data_o is don't-care while dataAvailable=0.
REQ-030 SHALL, on reset mid-transaction, drop all buffered and uncommitted data.

Structure
REQ-031 SHALL take the default depth constant USB_EP_IN_FIFO_DEPTH from the shared package usb_ep_pkg.
REQ-032 SHALL keep the FSM state enum local to this module.
REQ-033 SHALL infer storage inline as a single memory array, with no sub-module.
REQ-034 SHALL be instantiated once per IN endpoint, on the endpoint side of the usb_pe EP_IN_* bus.

Verification
REQ-035 SHALL cover: push 0x11,0x22,0x33; pop 3; TransDone+Success -> data 11,22,33 in order; dataAvailable=0; fillLevel=0.
REQ-036 SHALL cover: push 4 bytes, pop 2, TransDone with Success=0 -> rdPtr back; the next pops return bytes 1 and 2 again; fillLevel=4.
REQ-037 SHALL cover: DEPTH=4, push 5 bytes -> full_o=1 after the 4th; the 5th is dropped; pop 4 without commit keeps full_o=1; commit -> full_o=0.
REQ-038 SHALL cover: pop and TransDone+Success in the same cycle -> the popped byte is committed; with Success=0 the rollback includes that byte.
REQ-039 SHALL cover: 2*DEPTH+3 push/pop/commit cycles -> pointers wrap, with no false full or empty and data intact.
REQ-040 SHALL cover: reset asserted in ACTIVE with 3 uncommitted bytes -> next cycle all outputs are at reset values and state is IDLE.

Source files
------------

// File: rtl/usb_ep_pkg.sv
// Shared constants for the USB endpoint blocks.
package usb_ep_pkg;

  localparam int USB_EP_DATA_WID      = 8;
  localparam int USB_EP_IN_FIFO_DEPTH = 64;

endpackage

// File: rtl/usb_ep_in_fifo.sv
// IN endpoint FIFO with speculative read pointer and commit/rollback.
// Bytes read by the protocol engine are only freed when the host ACKs
// the transaction; a NAK/timeout rewinds the read pointer so the retry
// resends the same bytes.
module usb_ep_in_fifo
  import usb_ep_pkg::*;
#(
  parameter int EP_DATA_WID = USB_EP_DATA_WID,
  parameter int DEPTH       = USB_EP_IN_FIFO_DEPTH
) (
  input  logic                   clk48_i,
  input  logic                   rst_n_i,
  input  logic [EP_DATA_WID-1:0] wrData_i,
  input  logic                   wrValid_i,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] fillLevel_o,
  input  logic                   EP_IN_popData_i,
  input  logic                   EP_IN_popTransDone_i,
  input  logic                   EP_IN_popTransSuccess_i,
  output logic                   EP_IN_dataAvailable_o,
  output logic [EP_DATA_WID-1:0] EP_IN_data_o
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int AW = PW - 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [PW-1:0]          wrPtr_q, wrPtr_d;
  logic [PW-1:0]          rdPtr_q, rdPtr_d;
  logic [PW-1:0]          cmtPtr_q, cmtPtr_d;
  logic [EP_DATA_WID-1:0] mem_q [DEPTH];

  logic          push;
  logic          pop;
  logic [PW-1:0] fill;

  // Occupancy counts uncommitted bytes, so space frees only on commit.
  assign fill                  = wrPtr_q - cmtPtr_q;
  assign full_o                = (fill == PW'(DEPTH));
  assign fillLevel_o           = fill;
  assign EP_IN_dataAvailable_o = (rdPtr_q != wrPtr_q);
  assign EP_IN_data_o          = mem_q[rdPtr_q[AW-1:0]];

  assign push = wrValid_i && !full_o;
  assign pop  = EP_IN_popData_i && EP_IN_dataAvailable_o;

  // Next-state: pointer advance, commit/rollback and transaction FSM.
  always_comb begin
    state_d  = state_q;
    wrPtr_d  = wrPtr_q + PW'(push);
    rdPtr_d  = rdPtr_q + PW'(pop);
    cmtPtr_d = cmtPtr_q;
    // TransDone only matters once a byte of this transaction was read.
    if (EP_IN_popTransDone_i && (state_q == ACTIVE || pop)) begin
      state_d = IDLE;
      if (EP_IN_popTransSuccess_i) begin
        cmtPtr_d = rdPtr_q + PW'(pop);
      end else begin
        rdPtr_d = cmtPtr_q;
      end
    end else if (state_q == IDLE && pop) begin
      state_d = ACTIVE;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk48_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      cmtPtr_q <= '0;
    end else begin
      state_q  <= state_d;
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      cmtPtr_q <= cmtPtr_d;
    end
  end

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk48_i) begin
    if (push) begin
      mem_q[wrPtr_q[AW-1:0]] <= wrData_i;
    end
  end

endmodule

// File: tb/tb_usb_ep_in_fifo.sv
// Self-checking bench for usb_ep_in_fifo (DEPTH=4 instance).
module tb_usb_ep_in_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int FW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          full;
  logic [FW-1:0] fill;
  logic          pop = 1'b0;
  logic          done = 1'b0;
  logic          succ = 1'b0;
  logic          avail;
  logic [DW-1:0] rd_data;

  always #5 clk = ~clk;

  usb_ep_in_fifo #(.EP_DATA_WID(DW), .DEPTH(DEPTH)) dut (
    .clk48_i                 (clk),
    .rst_n_i                 (rst_n),
    .wrData_i                (wr_data),
    .wrValid_i               (wr_valid),
    .full_o                  (full),
    .fillLevel_o             (fill),
    .EP_IN_popData_i         (pop),
    .EP_IN_popTransDone_i    (done),
    .EP_IN_popTransSuccess_i (succ),
    .EP_IN_dataAvailable_o   (avail),
    .EP_IN_data_o            (rd_data)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: uncommitted bytes in order, speculative read index.
  logic [DW-1:0] m_q[$];
  int            m_rd  = 0;
  bit            m_act = 1'b0;
  // Scoreboard: expected bytes pushed by the model, observed bytes by the DUT.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];

  task automatic step(input logic p, input logic [DW-1:0] d, input logic pp,
                      input logic dn, input logic sc);
    bit push_v, pop_v;
    int n;
    @(negedge clk);
    wr_valid = p; wr_data = d; pop = pp; done = dn; succ = sc;
    #1;
    if (pp && avail) got_q.push_back(rd_data);
    push_v = p && (m_q.size() < DEPTH);
    pop_v  = pp && (m_rd < m_q.size());
    if (pop_v) exp_q.push_back(m_q[m_rd]);
    if (dn && (m_act || pop_v)) begin
      if (sc) begin
        n = m_rd + int'(pop_v);
        for (int k = 0; k < n; k++) void'(m_q.pop_front());
      end
      m_rd  = 0;
      m_act = 1'b0;
    end else begin
      m_rd = m_rd + int'(pop_v);
      if (pop_v) m_act = 1'b1;
    end
    if (push_v) m_q.push_back(d);
    @(posedge clk);
    #1;
    wr_valid = 1'b0; pop = 1'b0; done = 1'b0; succ = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; wr_valid = 1'b0; pop = 1'b0; done = 1'b0; succ = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_q.delete(); m_rd = 0; m_act = 1'b0;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
    checks++; if (fill !== '0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill); end
    checks++; if (avail !== 1'b0) begin failures++; $display("FAIL reset_avail got=%0b exp=0", avail); end
    checks++; if (dut.state_q !== 1'b0) begin failures++; $display("FAIL reset_state got=%0b exp=IDLE", dut.state_q); end
  endtask

  task automatic test_commit();
    logic [DW-1:0] g, e;
    step(1, 8'h11, 0, 0, 0); step(1, 8'h22, 0, 0, 0); step(1, 8'h33, 0, 0, 0);
    checks++; if (fill !== FW'(3) || avail !== 1'b1) begin failures++; $display("FAIL commit_loaded fill=%0d avail=%0b exp fill=3 avail=1", fill, avail); end
    repeat (3) step(0, 8'h00, 1, 0, 0);
    checks++; if (fill !== FW'(3)) begin failures++; $display("FAIL commit_pending fill=%0d exp=3", fill); end
    step(0, 8'h00, 0, 1, 1);
    checks++; if (fill !== '0 || avail !== 1'b0) begin failures++; $display("FAIL commit_done fill=%0d avail=%0b exp fill=0 avail=0", fill, avail); end
    step(0, 8'h00, 1, 0, 0);
    checks++; if (fill !== '0 || avail !== 1'b0 || got_q.size() != 3) begin failures++; $display("FAIL commit_empty_pop fill=%0d avail=%0b pops=%0d exp 0 0 3", fill, avail, got_q.size()); end
    checks++; if (got_q.size() < 3 || got_q[0] !== 8'h11 || got_q[1] !== 8'h22 || got_q[2] !== 8'h33) begin failures++; $display("FAIL commit_order got=%p exp=11,22,33", got_q); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL commit_sb_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL commit_sb_data got=%h exp=%h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_rollback();
    logic [DW-1:0] g, e;
    for (int i = 0; i < 4; i++) step(1, DW'(8'h41 + i), 0, 0, 0);
    step(0, 8'h00, 1, 0, 0); step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 1, 0);
    checks++; if (fill !== FW'(4) || avail !== 1'b1) begin failures++; $display("FAIL rollback_state fill=%0d avail=%0b exp fill=4 avail=1", fill, avail); end
    step(0, 8'h00, 1, 0, 0); step(0, 8'h00, 1, 0, 0);
    checks++; if (got_q.size() < 4 || got_q[0] !== 8'h41 || got_q[1] !== 8'h42 || got_q[2] !== 8'h41 || got_q[3] !== 8'h42) begin failures++; $display("FAIL rollback_resend got=%p exp=41,42,41,42", got_q); end
    step(0, 8'h00, 1, 0, 0); step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 1, 1);
    checks++; if (fill !== FW'(m_q.size()) || avail !== (m_rd < m_q.size())) begin failures++; $display("FAIL rollback_final fill=%0d avail=%0b exp fill=%0d", fill, avail, m_q.size()); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rollback_sb_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL rollback_sb_data got=%h exp=%h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_full();
    logic [DW-1:0] g, e;
    for (int i = 0; i < 3; i++) step(1, DW'(8'h51 + i), 0, 0, 0);
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_early got=%0b exp=0", full); end
    step(1, 8'h54, 0, 0, 0);
    checks++; if (full !== 1'b1 || fill !== FW'(4)) begin failures++; $display("FAIL full_set full=%0b fill=%0d exp 1 4", full, fill); end
    step(1, 8'h55, 0, 0, 0);
    checks++; if (full !== 1'b1 || fill !== FW'(4)) begin failures++; $display("FAIL full_drop full=%0b fill=%0d exp 1 4", full, fill); end
    repeat (4) step(0, 8'h00, 1, 0, 0);
    checks++; if (full !== 1'b1 || avail !== 1'b0) begin failures++; $display("FAIL full_pending full=%0b avail=%0b exp 1 0", full, avail); end
    step(0, 8'h00, 0, 1, 1);
    checks++; if (full !== 1'b0 || fill !== '0) begin failures++; $display("FAIL full_commit full=%0b fill=%0d exp 0 0", full, fill); end
    checks++; if (got_q.size() != 4 || got_q[0] !== 8'h51 || got_q[3] !== 8'h54) begin failures++; $display("FAIL full_data got=%p exp=51..54", got_q); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL full_sb_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL full_sb_data got=%h exp=%h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] g, e;
    step(1, 8'h61, 0, 0, 0); step(1, 8'h62, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 1, 1);
    checks++; if (fill !== '0 || avail !== 1'b0) begin failures++; $display("FAIL same_commit fill=%0d avail=%0b exp 0 0", fill, avail); end
    step(1, 8'h63, 0, 0, 0); step(1, 8'h64, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 1, 0);
    checks++; if (fill !== FW'(2) || avail !== 1'b1) begin failures++; $display("FAIL same_rollback fill=%0d avail=%0b exp 2 1", fill, avail); end
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 1, 1);
    checks++; if (fill !== '0 || avail !== 1'b0) begin failures++; $display("FAIL same_final fill=%0d avail=%0b exp 0 0", fill, avail); end
    checks++; if (got_q.size() != 6 || got_q[4] !== 8'h63 || got_q[5] !== 8'h64) begin failures++; $display("FAIL same_resend got=%p exp=61,62,63,64,63,64", got_q); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL same_sb_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL same_sb_data got=%h exp=%h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_wrap();
    logic [DW-1:0] g, e;
    step(1, 8'h80, 0, 0, 0);
    for (int i = 0; i < 2 * DEPTH + 3; i++) begin
      step(1, DW'(8'h81 + i), 1, 1, 1);
      checks++; if (full !== 1'b0 || fill !== FW'(1) || avail !== 1'b1) begin failures++; $display("FAIL wrap_iter%0d full=%0b fill=%0d avail=%0b exp 0 1 1", i, full, fill, avail); end
    end
    step(0, 8'h00, 1, 1, 1);
    checks++; if (fill !== '0 || avail !== 1'b0) begin failures++; $display("FAIL wrap_empty fill=%0d avail=%0b exp 0 0", fill, avail); end
    for (int i = 0; i < 4; i++) step(1, DW'(8'hA0 + i), 0, 0, 0);
    checks++; if (full !== 1'b1 || fill !== FW'(4)) begin failures++; $display("FAIL wrap_full full=%0b fill=%0d exp 1 4", full, fill); end
    repeat (3) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 1, 1);
    checks++; if (full !== 1'b0 || avail !== 1'b0) begin failures++; $display("FAIL wrap_drain full=%0b avail=%0b exp 0 0", full, avail); end
    for (int i = 0; i < 2 * DEPTH + 4 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== DW'(8'h80 + i)) begin failures++; $display("FAIL wrap_data%0d got=%h exp=%h", i, got_q[i], DW'(8'h80 + i)); end
    end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL wrap_sb_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL wrap_sb_data got=%h exp=%h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] g, e;
    step(1, 8'h71, 0, 0, 0); step(1, 8'h72, 0, 0, 0); step(1, 8'h73, 0, 0, 0);
    repeat (3) step(0, 8'h00, 1, 0, 0);
    checks++; if (fill !== FW'(3) || dut.state_q !== 1'b1) begin failures++; $display("FAIL mid_active fill=%0d state=%0b exp 3 ACTIVE", fill, dut.state_q); end
    do_reset();
    checks++; if (full !== 1'b0 || fill !== '0 || avail !== 1'b0) begin failures++; $display("FAIL mid_reset full=%0b fill=%0d avail=%0b exp 0 0 0", full, fill, avail); end
    checks++; if (dut.state_q !== 1'b0) begin failures++; $display("FAIL mid_state got=%0b exp=IDLE", dut.state_q); end
    step(1, 8'h74, 0, 0, 0); step(1, 8'h75, 0, 0, 0);
    step(0, 8'h00, 0, 1, 1);
    step(0, 8'h00, 0, 1, 0);
    checks++; if (fill !== FW'(2) || avail !== 1'b1) begin failures++; $display("FAIL idle_done fill=%0d avail=%0b exp 2 1", fill, avail); end
    step(0, 8'h00, 1, 1, 1);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h74 || fill !== FW'(1)) begin failures++; $display("FAIL idle_after got=%p fill=%0d exp 74 1", got_q, fill); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL mid_sb_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL mid_sb_data got=%h exp=%h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_commit();
    test_rollback();
    test_full();
    test_same_cycle();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
